// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Purpose : request/result bundle between a requester and serial_add_ctrl.
// Signals : start  - request, sampled by the sequencer in IDLE or DONE
//           clr    - synchronous abort, returns the sequencer to IDLE
//           A, B   - WIDTH-bit operands, captured on an accepted start
//           CIN    - initial carry-in, captured on an accepted start
//           busy   - high while the addition is in progress
//           done   - one-cycle pulse, SUM/COUT newly updated
//           SUM    - WIDTH-bit result, held until next completion/clr/reset
//           COUT   - final carry-out, held with SUM
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             clr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             COUT;

  modport master (
    output start, clr, A, B, CIN,
    input  busy, done, SUM, COUT
  );

  modport slave (
    input  start, clr, A, B, CIN,
    output busy, done, SUM, COUT
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Purpose : bit-serial WIDTH-bit adder sequencer. One full-adder evaluation per
//           clock, LSB first, with a carry flop linking consecutive bits.
//           Owns the operand shift registers, bit counter and result register.
// Ports   : CLK - clock, rising edge
//           RST - asynchronous active-high reset, clears all state
//           bus - serial_add_ctrl_if.slave (start/clr/A/B/CIN in,
//                 busy/done/SUM/COUT out, all outputs registered)
// Latency : start sampled at edge k -> done high after edge k+WIDTH.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  serial_add_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADD  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Full-adder cell equations.
  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (ci & (a ^ b));
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] r_sr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             bit_sum_s;
  logic             bit_carry_s;
  logic             last_bit_s;

  assign bit_sum_s   = fa_sum(a_sr_r[0], b_sr_r[0], carry_r);
  assign bit_carry_s = fa_carry(a_sr_r[0], b_sr_r[0], carry_r);
  assign last_bit_s  = (cnt_r == CNT_W'(WIDTH - 1));

  // Sequencer FSM with operand capture, serial datapath and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      r_sr_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else if (bus.clr) begin
      // Abort wins over a simultaneous start; the in-flight result is dropped.
      state_r <= ST_IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      r_sr_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr_r  <= bus.A;
            b_sr_r  <= bus.B;
            carry_r <= bus.CIN;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_ADD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_ADD: begin
          // start is ignored here; operands were already captured.
          a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          r_sr_r  <= {bit_sum_s, r_sr_r[WIDTH-1:1]};
          carry_r <= bit_carry_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            sum_r   <= {bit_sum_s, r_sr_r[WIDTH-1:1]};
            cout_r  <= bit_carry_s;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_ADD;
          end
        end

        ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            // Back-to-back request: reload straight from DONE.
            a_sr_r  <= bus.A;
            b_sr_r  <= bus.B;
            carry_r <= bus.CIN;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_ADD;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        default: begin
          // Unreachable encoding 2'b11: recover to IDLE.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          cnt_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.SUM  = sum_r;
  assign bus.COUT = cout_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Purpose : directed self-checking bench for serial_add_ctrl (WIDTH=8).
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_mis;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Tick until done is seen (bounded); returns number of ticks taken.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Count done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  // One complete request with latency and result checks.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    bus.A = a; bus.B = b; bus.CIN = cin; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_nodone"}, bus.done, 0);
    wait_done(n);
    // start sampled at the first tick; done is up after WIDTH further edges.
    chk({tag, "_lat"}, n, W);
    chk({tag, "_busy_off"}, bus.busy, 0);
    chk({tag, "_sum"}, bus.SUM, exp_sum);
    chk({tag, "_cout"}, bus.COUT, exp_cout);
    tick();
    chk({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int n;
    int pulses;
    n_cmp = 0;
    n_mis = 0;
    RST = 1'b1;
    bus.start = 1'b0; bus.clr = 1'b0;
    bus.A = 8'h00; bus.B = 8'h00; bus.CIN = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.SUM, 0);
    chk("rst_cout", bus.COUT, 0);
    #2 RST = 1'b0;
    tick();

    // 1. basic addition
    run_op("t1", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);

    // 2. wrap with carry-out, and carry-in propagation
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

    // 3. start held high across DONE
    bus.A = 8'h10; bus.B = 8'h20; bus.CIN = 1'b0; bus.start = 1'b1;
    tick();
    bus.A = 8'h80; bus.B = 8'h80; bus.CIN = 1'b1;
    wait_done(n);
    chk("t3_lat1", n, W);
    chk("t3_sum1", bus.SUM, 8'h30);
    chk("t3_cout1", bus.COUT, 0);
    chk("t3_bsy1", bus.busy, 0);
    tick();
    // The DONE cycle samples the held start and reloads.
    chk("t3_reload_busy", bus.busy, 1);
    chk("t3_reload_done", bus.done, 0);
    wait_done(n);
    // Second pulse arrives WIDTH edges after the DONE-cycle sample.
    chk("t3_lat2", n, W);
    chk("t3_sum2", bus.SUM, 8'h01);
    chk("t3_cout2", bus.COUT, 1);
    bus.start = 1'b0;
    tick();
    chk("t3_idle_busy", bus.busy, 0);
    chk("t3_idle_done", bus.done, 0);

    // 4. operands changed and start re-pulsed mid-ADD are ignored
    bus.A = 8'h12; bus.B = 8'h34; bus.CIN = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    bus.A = 8'hFF; bus.B = 8'hFF; bus.CIN = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(n);
    chk("t4_lat", n + 4, W);
    chk("t4_sum", bus.SUM, 8'h46);
    chk("t4_cout", bus.COUT, 0);
    count_done(12, pulses);
    chk("t4_single_done", pulses, 0);
    chk("t4_busy", bus.busy, 0);

    // 5. clr with simultaneous start mid-ADD
    bus.A = 8'h5A; bus.B = 8'h33; bus.CIN = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.clr = 1'b1; bus.start = 1'b1;
    tick();
    bus.clr = 1'b0; bus.start = 1'b0;
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_sum", bus.SUM, 0);
    chk("t5_cout", bus.COUT, 0);
    count_done(12, pulses);
    chk("t5_nodone", pulses, 0);
    chk("t5_busy_after", bus.busy, 0);

    // 6. async reset mid-ADD
    run_op("t6pre", 8'h0F, 8'hF1, 1'b0, 8'h00, 1'b1);
    run_op("t6pre2", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    bus.A = 8'hC3; bus.B = 8'h3C; bus.CIN = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    #2 RST = 1'b1;
    #1;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_sum", bus.SUM, 0);
    chk("t6_cout", bus.COUT, 0);
    #1 RST = 1'b0;
    count_done(12, pulses);
    chk("t6_nodone", pulses, 0);
    run_op("t6post", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
